// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmit engine: bit timer, shift register and framing FSM
module uart_tx_core #(
    parameter int MAX_DATA_BITS = 9,
    parameter int CLK_DIV_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop_bits,
    input  logic [CLK_DIV_W-1:0]     cfg_clk_div,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    input  logic                     tx_break,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                   state_q;
    logic [CLK_DIV_W-1:0]     timer_q;
    logic [CLK_DIV_W-1:0]     div_q;
    logic [3:0]               bit_idx_q;
    logic [3:0]               nbits_q;
    logic [MAX_DATA_BITS-1:0] shreg_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     two_stop_q;
    logic                     brk_q;
    logic                     tx_q;

    logic [CLK_DIV_W-1:0]     div_m1;
    logic [3:0]               nbits_eff;
    logic [MAX_DATA_BITS-1:0] mask;
    logic                     bit_end;
    logic                     last_stop;
    logic                     stop_end;
    logic                     accept;

    // Clamp the incoming frame configuration and build the data-field mask
    always_comb begin
        div_m1 = (cfg_clk_div == '0) ? '0 : cfg_clk_div - CLK_DIV_W'(1);
        if (cfg_data_bits < 4'd5) begin
            nbits_eff = 4'd5;
        end else if (cfg_data_bits > 4'(MAX_DATA_BITS)) begin
            nbits_eff = 4'(MAX_DATA_BITS);
        end else begin
            nbits_eff = cfg_data_bits;
        end
        mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            mask[i] = (i < int'(nbits_eff));
        end
    end

    assign bit_end   = (timer_q == '0);
    assign last_stop = (bit_idx_q == {3'b000, two_stop_q});
    assign stop_end  = (state_q == S_STOP) && last_stop && bit_end;
    // The stop bit after a break also opens the handshake so a queued word follows without a gap
    assign tx_ready  = rst_n && !tx_break && ((state_q == S_IDLE) || stop_end);
    assign accept    = tx_valid && tx_ready;
    assign done      = stop_end && !brk_q;
    assign busy      = (state_q != S_IDLE);
    assign tx        = tx_q;

    // Framing FSM: timer, shifter and registered line output advance together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            brk_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            if (!bit_end) begin
                timer_q <= timer_q - CLK_DIV_W'(1);
            end
            if (accept) begin
                state_q    <= S_START;
                tx_q       <= 1'b0;
                timer_q    <= div_m1;
                div_q      <= div_m1;
                bit_idx_q  <= '0;
                nbits_q    <= nbits_eff;
                shreg_q    <= tx_data & mask;
                par_en_q   <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
                par_bit_q  <= (^(tx_data & mask)) ^ (cfg_parity == 2'd2);
                two_stop_q <= cfg_stop_bits;
                brk_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tx_break) begin
                            state_q   <= S_BREAK;
                            tx_q      <= 1'b0;
                            timer_q   <= div_m1;
                            div_q     <= div_m1;
                            bit_idx_q <= '0;
                            brk_q     <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (bit_end) begin
                            state_q   <= S_DATA;
                            tx_q      <= shreg_q[0];
                            timer_q   <= div_q;
                            bit_idx_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            timer_q <= div_q;
                            if (bit_idx_q == nbits_q - 4'd1) begin
                                bit_idx_q <= '0;
                                if (par_en_q) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_bit_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                                shreg_q   <= shreg_q >> 1;
                                tx_q      <= shreg_q[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state_q   <= S_STOP;
                            tx_q      <= 1'b1;
                            timer_q   <= div_q;
                            bit_idx_q <= '0;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (last_stop) begin
                                state_q <= S_IDLE;
                                brk_q   <= 1'b0;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                                timer_q   <= div_q;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (bit_end) begin
                            timer_q <= div_q;
                            if (!tx_break) begin
                                state_q    <= S_STOP;
                                tx_q       <= 1'b1;
                                bit_idx_q  <= '0;
                                two_stop_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed bench for uart_tx_core
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop_bits;
    logic [15:0] cfg_clk_div;
    logic       tx_valid;
    logic [8:0] tx_data;
    logic       tx_ready;
    logic       tx_break;
    logic       tx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    uart_tx_core #(.MAX_DATA_BITS(9), .CLK_DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
        .cfg_stop_bits(cfg_stop_bits), .cfg_clk_div(cfg_clk_div),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_break(tx_break), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic sb, input logic [15:0] div);
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop_bits = sb;
        cfg_clk_div   = div;
    endtask

    // bits[0] is the first bit on the line; called in the first cycle of the start bit
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nb, input int div);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), tx, bits[b]);
                chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), done,
                    ((b == nb - 1) && (c == div - 1)) ? 1 : 0);
                tick(1);
            end
        end
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_tx"}, tx, 1);
    endtask

    task automatic send(input logic [8:0] data);
        tx_data  = data;
        tx_valid = 1'b1;
        chk("send_ready", tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    logic [8:0]  words [3];
    logic [15:0] wbits [3];

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_break = 1'b0;
        tx_data  = '0;
        set_cfg(4'd8, 2'd0, 1'b0, 16'd4);
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tx_ready, 0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ready", tx_ready, 1);

        // 8N1, div 4, 0x55
        set_cfg(4'd8, 2'd0, 1'b0, 16'd4);
        send(9'h055);
        check_frame("f8n1", 16'h02AA, 10, 4);

        // 7E1, div 2, 0x41
        set_cfg(4'd7, 2'd1, 1'b0, 16'd2);
        send(9'h041);
        check_frame("f7e1", 16'h0282, 10, 2);

        // 8O2, div 2, 0xFF
        set_cfg(4'd8, 2'd2, 1'b1, 16'd2);
        send(9'h0FF);
        check_frame("f8o2", 16'h0FFE, 12, 2);

        // data width above the maximum clamps to 9 bits, even parity over bit 8
        set_cfg(4'd15, 2'd1, 1'b0, 16'd1);
        send(9'h100);
        check_frame("f9e1", 16'h0E00, 12, 1);

        // divisor 0 and 2 data bits: 1 cycle per bit, 5 data bits; config change mid-frame ignored
        set_cfg(4'd2, 2'd0, 1'b0, 16'd0);
        send(9'h1F6);
        set_cfg(4'd8, 2'd2, 1'b1, 16'd3);
        tx_data = 9'h000;
        check_frame("f5n1", 16'h006C, 7, 1);

        // back-to-back, 8N1, div 1, valid held high
        words[0] = 9'h00F; wbits[0] = 16'h021E;
        words[1] = 9'h0A5; wbits[1] = 16'h034A;
        words[2] = 9'h03C; wbits[2] = 16'h0278;
        set_cfg(4'd8, 2'd0, 1'b0, 16'd1);
        tx_data  = words[0];
        tx_valid = 1'b1;
        tick(1);
        tx_data = words[1];
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 10; b++) begin
                chk($sformatf("b2b_f%0d_tx_b%0d", f, b), tx, wbits[f][b]);
                chk($sformatf("b2b_f%0d_busy_b%0d", f, b), busy, 1);
                chk($sformatf("b2b_f%0d_done_b%0d", f, b), done, (b == 9) ? 1 : 0);
                if (b == 9 && f < 2) begin
                    chk($sformatf("b2b_f%0d_accept", f), tx_ready & tx_valid, 1);
                end
                tick(1);
            end
            if (f == 0) tx_data = words[2];
            if (f == 1) tx_valid = 1'b0;
        end
        chk("b2b_idle_busy", busy, 0);

        // break for 10 cycles in IDLE with a word waiting, div 4
        set_cfg(4'd8, 2'd0, 1'b0, 16'd4);
        tx_data  = 9'h000;
        tx_valid = 1'b1;
        tx_break = 1'b1;
        #1;
        chk("brk_ready_c0", tx_ready, 0);
        tick(1);
        for (int i = 1; i <= 12; i++) begin
            if (i == 10) tx_break = 1'b0;
            chk($sformatf("brk_tx_low_c%0d", i), tx, 0);
            chk($sformatf("brk_ready_c%0d", i), tx_ready, 0);
            tick(1);
        end
        for (int i = 13; i <= 16; i++) begin
            chk($sformatf("brk_tx_high_c%0d", i), tx, 1);
            chk($sformatf("brk_done_c%0d", i), done, 0);
            chk($sformatf("brk_ready_c%0d", i), tx_ready, (i == 16) ? 1 : 0);
            tick(1);
        end
        tx_valid = 1'b0;
        check_frame("fbrk", 16'h0200, 10, 4);

        // reset during a data bit
        set_cfg(4'd8, 2'd0, 1'b0, 16'd4);
        send(9'h055);
        tick(18);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", tx_ready, 0);
        tick(1);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        tick(1);
        chk("mid_rel_ready", tx_ready, 1);
        send(9'h0A5);
        check_frame("fpost", 16'h034A, 10, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
